// File: rtl/game_pkg.sv
// ============================================================================
// game_pkg : shared state encoding, widths and default screen/bird geometry
// Rev 1.0
// ============================================================================
`default_nettype none

package game_pkg;

    localparam int c_NUM_TUBES = 3;
    localparam int c_COORD_W   = 11;
    localparam int c_CMP_W     = 12;
    localparam int c_SCORE_W   = 10;

    localparam logic [c_SCORE_W-1:0] c_SCORE_MAX = 10'd999;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_PLAY = 2'd1;
    localparam logic [1:0] c_ST_DEAD = 2'd2;
    localparam logic [1:0] c_ST_OVER = 2'd3;

    localparam int c_DEF_SCREEN_HEIGHT = 768;
    localparam int c_DEF_TUBE_WIDTH    = 120;
    localparam int c_DEF_GAP_HEIGHT    = 250;
    localparam int c_DEF_BIRD_X        = 200;
    localparam int c_DEF_BIRD_SIZE     = 40;
    localparam int c_DEF_DEATH_FRAMES  = 60;

    // Zero-extend a screen coordinate so sums never wrap.
    function automatic logic [c_CMP_W-1:0] f_ext(input logic [c_COORD_W-1:0] v);
        return {1'b0, v};
    endfunction

endpackage

`default_nettype wire

// File: rtl/game_ctrl_tube_hit.sv
// ============================================================================
// tube_hit : overlap / gap-safety / pass detection for one tube
// Rev 1.0
// ============================================================================
`default_nettype none

module tube_hit
    import game_pkg::*;
#(
    parameter int TUBE_WIDTH = c_DEF_TUBE_WIDTH,
    parameter int GAP_HEIGHT = c_DEF_GAP_HEIGHT,
    parameter int BIRD_X     = c_DEF_BIRD_X,
    parameter int BIRD_SIZE  = c_DEF_BIRD_SIZE
) (
    input  logic [c_COORD_W-1:0] i_tube_x,
    input  logic [c_COORD_W-1:0] i_prev_x,
    input  logic [c_COORD_W-1:0] i_gap_y,
    input  logic [c_COORD_W-1:0] i_bird_y,
    output logic                 o_hit,
    output logic                 o_pass
);

    localparam logic [c_CMP_W-1:0] c_X_LO = c_CMP_W'(BIRD_X);
    localparam logic [c_CMP_W-1:0] c_X_HI = c_CMP_W'(BIRD_X + BIRD_SIZE + TUBE_WIDTH);
    localparam logic [c_CMP_W-1:0] c_SIZE = c_CMP_W'(BIRD_SIZE);
    localparam logic [c_CMP_W-1:0] c_GAP  = c_CMP_W'(GAP_HEIGHT);

    logic [c_CMP_W-1:0] w_x;
    logic [c_CMP_W-1:0] w_prev;
    logic [c_CMP_W-1:0] w_gap;
    logic [c_CMP_W-1:0] w_bird;
    logic               w_overlap;
    logic               w_safe;

    assign w_x    = f_ext(i_tube_x);
    assign w_prev = f_ext(i_prev_x);
    assign w_gap  = f_ext(i_gap_y);
    assign w_bird = f_ext(i_bird_y);

    assign w_overlap = (w_x > c_X_LO) && (w_x < c_X_HI);
    assign w_safe    = (w_gap <= w_bird) && ((w_bird + c_SIZE) <= (w_gap + c_GAP));

    assign o_hit  = w_overlap && !w_safe;
    // Only a right-to-left crossing of the bird column scores; a wrap jumps upward.
    assign o_pass = (w_prev >= c_X_LO) && (w_x < c_X_LO);

endmodule

`default_nettype wire

// File: rtl/game_ctrl.sv
// ============================================================================
// game_ctrl : IDLE/PLAY/DEAD/OVER game FSM with collision, scoring and high score
// Rev 1.0
// ============================================================================
`default_nettype none

module game_ctrl
    import game_pkg::*;
#(
    parameter int SCREEN_HEIGHT = c_DEF_SCREEN_HEIGHT,
    parameter int TUBE_WIDTH    = c_DEF_TUBE_WIDTH,
    parameter int GAP_HEIGHT    = c_DEF_GAP_HEIGHT,
    parameter int BIRD_X        = c_DEF_BIRD_X,
    parameter int BIRD_SIZE     = c_DEF_BIRD_SIZE,
    parameter int DEATH_FRAMES  = c_DEF_DEATH_FRAMES
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   btn_flap,
    input  logic                                   frame_tick,
    input  logic [c_NUM_TUBES-1:0][c_COORD_W-1:0]  tube_x,
    input  logic [c_NUM_TUBES-1:0][c_COORD_W-1:0]  gap_y,
    input  logic [c_COORD_W-1:0]                   bird_y,
    output logic                                   game_rst,
    output logic                                   run,
    output logic                                   flap,
    output logic [1:0]                             state,
    output logic [c_SCORE_W-1:0]                   score,
    output logic [c_SCORE_W-1:0]                   high_score
);

    localparam int                   c_FRAME_W    = $clog2(DEATH_FRAMES + 1);
    localparam logic [c_FRAME_W-1:0] c_FRAME_LAST = c_FRAME_W'(DEATH_FRAMES - 1);
    localparam logic [c_CMP_W-1:0]   c_SIZE       = c_CMP_W'(BIRD_SIZE);
    localparam logic [c_CMP_W-1:0]   c_SCREEN     = c_CMP_W'(SCREEN_HEIGHT);

    logic [1:0]                            r_state;
    logic [c_SCORE_W-1:0]                  r_score;
    logic [c_SCORE_W-1:0]                  r_high;
    logic [c_FRAME_W-1:0]                  r_frames;
    logic [c_NUM_TUBES-1:0][c_COORD_W-1:0] r_prev_x;
    logic                                  r_game_rst;
    logic                                  r_run;
    logic                                  r_flap;

    logic [c_NUM_TUBES-1:0] w_tube_hit;
    logic [c_NUM_TUBES-1:0] w_pass;
    logic                   w_hit;
    logic                   w_start;
    logic [1:0]             w_pass_cnt;
    logic [c_SCORE_W:0]     w_score_sum;
    logic [c_SCORE_W-1:0]   w_score_next;
    logic [1:0]             w_next_state;

    generate
        for (genvar gi = 0; gi < c_NUM_TUBES; gi++) begin : g_tube
            tube_hit #(
                .TUBE_WIDTH (TUBE_WIDTH),
                .GAP_HEIGHT (GAP_HEIGHT),
                .BIRD_X     (BIRD_X),
                .BIRD_SIZE  (BIRD_SIZE)
            ) u_tube_hit (
                .i_tube_x (tube_x[gi]),
                .i_prev_x (r_prev_x[gi]),
                .i_gap_y  (gap_y[gi]),
                .i_bird_y (bird_y),
                .o_hit    (w_tube_hit[gi]),
                .o_pass   (w_pass[gi])
            );
        end
    endgenerate

    assign w_hit = (|w_tube_hit) || (bird_y == '0) || ((f_ext(bird_y) + c_SIZE) >= c_SCREEN);

    assign w_pass_cnt   = {1'b0, w_pass[0]} + {1'b0, w_pass[1]} + {1'b0, w_pass[2]};
    assign w_score_sum  = {1'b0, r_score} + {{(c_SCORE_W - 1){1'b0}}, w_pass_cnt};
    assign w_score_next = (w_score_sum > {1'b0, c_SCORE_MAX}) ? c_SCORE_MAX : w_score_sum[c_SCORE_W-1:0];

    assign w_start = btn_flap && ((r_state == c_ST_IDLE) || (r_state == c_ST_OVER));

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE, c_ST_OVER: if (btn_flap)   w_next_state = c_ST_PLAY;
            c_ST_PLAY:            if (w_hit)      w_next_state = c_ST_DEAD;
            c_ST_DEAD:            if (frame_tick && (r_frames == c_FRAME_LAST))
                                                  w_next_state = c_ST_OVER;
            default:                              w_next_state = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_score    <= '0;
            r_high     <= '0;
            r_frames   <= '0;
            r_prev_x   <= '0;
            r_game_rst <= 1'b0;
            r_run      <= 1'b0;
            r_flap     <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_prev_x   <= tube_x;
            r_game_rst <= w_start;
            r_run      <= (w_next_state == c_ST_PLAY);
            r_flap     <= btn_flap && (r_state == c_ST_PLAY) && (w_next_state == c_ST_PLAY);

            // A hit in the same cycle as a pass wins: the pass is not scored.
            if (w_start) begin
                r_score <= '0;
            end else if ((r_state == c_ST_PLAY) && !w_hit) begin
                r_score <= w_score_next;
            end

            if ((r_state == c_ST_PLAY) && w_hit) begin
                if (r_score > r_high) begin
                    r_high <= r_score;
                end
                r_frames <= '0;
            end else if ((r_state == c_ST_DEAD) && frame_tick) begin
                r_frames <= r_frames + 1'b1;
            end
        end
    end

    assign game_rst   = r_game_rst;
    assign run        = r_run;
    assign flap       = r_flap;
    assign state      = r_state;
    assign score      = r_score;
    assign high_score = r_high;

endmodule

`default_nettype wire

// File: tb/tb_game_ctrl.sv
// ============================================================================
// tb_game_ctrl : directed scenarios plus random play against a behavioural model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_game_ctrl;

    localparam int SCREEN_HEIGHT = 768;
    localparam int TUBE_WIDTH    = 120;
    localparam int GAP_HEIGHT    = 250;
    localparam int BIRD_X        = 200;
    localparam int BIRD_SIZE     = 40;
    localparam int DEATH_FRAMES  = 60;

    localparam int ST_IDLE = 0;
    localparam int ST_PLAY = 1;
    localparam int ST_DEAD = 2;
    localparam int ST_OVER = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             btn_flap;
    logic             frame_tick;
    logic [2:0][10:0] tube_x;
    logic [2:0][10:0] gap_y;
    logic [10:0]      bird_y;
    logic             game_rst;
    logic             run;
    logic             flap;
    logic [1:0]       state;
    logic [9:0]       score;
    logic [9:0]       high_score;

    int n_checks = 0;
    int n_errors = 0;

    // Model state kept as plain integers.
    int m_state;
    int m_score;
    int m_hi;
    int m_frames;
    int m_prev [3];
    int m_run;
    int m_flap;
    int m_grst;

    always #5 clk = ~clk;

    game_ctrl #(
        .SCREEN_HEIGHT (SCREEN_HEIGHT),
        .TUBE_WIDTH    (TUBE_WIDTH),
        .GAP_HEIGHT    (GAP_HEIGHT),
        .BIRD_X        (BIRD_X),
        .BIRD_SIZE     (BIRD_SIZE),
        .DEATH_FRAMES  (DEATH_FRAMES)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .btn_flap   (btn_flap),
        .frame_tick (frame_tick),
        .tube_x     (tube_x),
        .gap_y      (gap_y),
        .bird_y     (bird_y),
        .game_rst   (game_rst),
        .run        (run),
        .flap       (flap),
        .state      (state),
        .score      (score),
        .high_score (high_score)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit ref_hit();
        int by;
        by = int'(bird_y);
        if (by == 0 || by + BIRD_SIZE >= SCREEN_HEIGHT) return 1'b1;
        for (int i = 0; i < 3; i++) begin
            int tx, gy;
            tx = int'(tube_x[i]);
            gy = int'(gap_y[i]);
            if (tx > BIRD_X && tx < BIRD_X + BIRD_SIZE + TUBE_WIDTH &&
                !(gy <= by && by + BIRD_SIZE <= gy + GAP_HEIGHT))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_edge();
        int  ns, passes, start;
        bit  hit;
        hit    = ref_hit();
        passes = 0;
        for (int i = 0; i < 3; i++)
            if (m_prev[i] >= BIRD_X && int'(tube_x[i]) < BIRD_X) passes++;
        if (rst) begin
            m_state = ST_IDLE; m_score = 0; m_hi = 0; m_frames = 0;
            m_run = 0; m_flap = 0; m_grst = 0;
            for (int i = 0; i < 3; i++) m_prev[i] = 0;
            return;
        end
        ns    = m_state;
        start = 0;
        case (m_state)
            ST_IDLE, ST_OVER: if (btn_flap) begin start = 1; m_score = 0; ns = ST_PLAY; end
            ST_PLAY: begin
                if (hit) begin
                    ns = ST_DEAD;
                    if (m_score > m_hi) m_hi = m_score;
                    m_frames = 0;
                end else begin
                    m_score = (m_score + passes > 999) ? 999 : m_score + passes;
                end
            end
            default: if (frame_tick) begin
                m_frames++;
                if (m_frames == DEATH_FRAMES) ns = ST_OVER;
            end
        endcase
        m_flap  = (m_state == ST_PLAY && btn_flap && ns == ST_PLAY) ? 1 : 0;
        m_grst  = start;
        m_run   = (ns == ST_PLAY) ? 1 : 0;
        m_state = ns;
        for (int i = 0; i < 3; i++) m_prev[i] = int'(tube_x[i]);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_val("state",      state,      m_state);
        check_val("run",        run,        m_run);
        check_val("flap",       flap,       m_flap);
        check_val("game_rst",   game_rst,   m_grst);
        check_val("score",      score,      m_score);
        check_val("high_score", high_score, m_hi);
    endtask

    task automatic press();
        btn_flap = 1'b1;
        cycle();
        btn_flap = 1'b0;
    endtask

    initial begin
        rst = 1'b1; btn_flap = 1'b0; frame_tick = 1'b0;
        tube_x = {3{11'd1500}};
        gap_y  = {3{11'd100}};
        bird_y = 11'd300;
        repeat (2) cycle();
        check_val("rst_state", state, ST_IDLE);
        check_val("rst_score", score, 0);
        rst = 1'b0;
        cycle();

        // Start from IDLE
        press();
        check_val("start_grst", game_rst, 1);
        check_val("start_state", state, ST_PLAY);
        check_val("start_run", run, 1);
        cycle();
        check_val("grst_one_cycle", game_rst, 0);

        // Collision against tube 0
        tube_x[0] = 11'd300; gap_y[0] = 11'd100; bird_y = 11'd150;
        repeat (3) cycle();
        check_val("safe_play", state, ST_PLAY);
        bird_y = 11'd311;
        cycle();
        check_val("hit_dead", state, ST_DEAD);
        check_val("hit_run", run, 0);

        // Death timer, flap ignored while dead
        bird_y = 11'd150;
        press();
        check_val("dead_ignores_flap", state, ST_DEAD);
        for (int k = 0; k < 59; k++) begin
            frame_tick = 1'b1; cycle();
            frame_tick = 1'b0; cycle();
        end
        check_val("dead_59", state, ST_DEAD);
        frame_tick = 1'b1; cycle(); frame_tick = 1'b0;
        check_val("over_60", state, ST_OVER);
        press();
        check_val("restart_state", state, ST_PLAY);

        // Scoring on tube 1
        tube_x[0] = 11'd1500;
        tube_x[1] = 11'd202; gap_y[1] = 11'd100;
        cycle();
        tube_x[1] = 11'd200; cycle();
        check_val("pass_at_edge", score, 0);
        tube_x[1] = 11'd198; cycle();
        check_val("pass_count", score, 1);
        tube_x[1] = 11'd2;   cycle();
        tube_x[1] = 11'd240; cycle();
        check_val("wrap_no_pass", score, 1);

        // Floor
        bird_y = 11'd728;
        cycle();
        check_val("floor_dead", state, ST_DEAD);
        check_val("floor_high", high_score, 1);
        bird_y = 11'd150;
        frame_tick = 1'b1; repeat (60) cycle(); frame_tick = 1'b0;
        check_val("over_b2b", state, ST_OVER);
        press();
        check_val("restart_score", score, 0);
        check_val("restart_high", high_score, 1);

        // Five passes, then reset overrides a simultaneous hit and flap
        repeat (5) begin
            tube_x[1] = 11'd250; cycle();
            tube_x[1] = 11'd150; cycle();
        end
        check_val("five_pass", score, 5);
        rst = 1'b1; btn_flap = 1'b1; bird_y = 11'd0;
        cycle();
        rst = 1'b0; btn_flap = 1'b0; bird_y = 11'd150;
        check_val("rst_mid_state", state, ST_IDLE);
        check_val("rst_mid_score", score, 0);
        check_val("rst_mid_high", high_score, 0);
        check_val("rst_mid_run", run, 0);

        // Score saturation: three passes every two cycles
        tube_x = {3{11'd1500}};
        press();
        repeat (700) begin
            tube_x = {3{11'd250}}; cycle();
            tube_x = {3{11'd150}}; cycle();
        end
        check_val("saturate", score, 999);

        // Random play
        tube_x = {11'd700, 11'd1100, 11'd1500};
        for (int n = 0; n < 3000; n++) begin
            rst        = ($urandom_range(0, 399) == 0);
            btn_flap   = ($urandom_range(0, 15) == 0);
            frame_tick = $urandom_range(0, 1) == 1;
            for (int i = 0; i < 3; i++) begin
                int dec;
                dec = int'($urandom_range(0, 4));
                if (int'(tube_x[i]) < dec + 5) begin
                    tube_x[i] = 11'($urandom_range(600, 1400));
                    gap_y[i]  = 11'($urandom_range(140, 300));
                end else begin
                    tube_x[i] = tube_x[i] - 11'(dec);
                end
            end
            case ($urandom_range(0, 199))
                0:       bird_y = 11'd0;
                1, 2:    bird_y = 11'($urandom_range(720, 2047));
                default: bird_y = 11'($urandom_range(280, 320));
            endcase
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 SHALL have parameter SCREEN_HEIGHT, default 768, screen height in pixels.
REQ-002 SHALL have parameter TUBE_WIDTH, default 120, tube width in pixels.
REQ-003 SHALL have parameter GAP_HEIGHT, default 250, vertical gap height in pixels.
REQ-004 SHALL have parameter BIRD_X, default 200, fixed left column of the bird.
REQ-005 SHALL have parameter BIRD_SIZE, default 40, bird square side in pixels.
REQ-006 SHALL have parameter DEATH_FRAMES, default 60, number of frames spent in DEAD.
REQ-007 SHALL have one clock and a synchronous, active-high reset: clk  in  1  system clock; rst  in  1  synchronous active-high reset.
REQ-008 SHALL have these ports:
- btn_flap  in  1  debounced one-cycle flap pulse.
- frame_tick  in  1  one-cycle pulse per frame.
- tube_x  in  11x3  tube right edges.
- gap_y  in  11x3  gap top rows.
- bird_y  in  11  bird top row.
- game_rst  out  1  one-cycle pulse that restarts the tube and bird datapaths.
- run  out  1  datapaths advance while high.
- flap  out  1  btn_flap gated to PLAY.
- state  out  2  current FSM state.
- score  out  10  current score.
- high_score  out  10  best score.

Function
REQ-009 SHALL implement states IDLE=0, PLAY=1, DEAD=2 and OVER=3.
REQ-010 SHALL define IDLE transitions:
- btn_flap in IDLE: game_rst=1 for exactly that clock's following cycle, score<=0, next state PLAY.
- run=0 while in IDLE.
REQ-011 SHALL set run=1 only in PLAY, and set flap=btn_flap only in PLAY (flap=0 elsewhere).
REQ-012 SHALL treat tube i as occupying columns tube_x[i]-TUBE_WIDTH .. tube_x[i]-1.
REQ-013 SHALL detect horizontal overlap of tube i with the bird when BIRD_X < tube_x[i] < BIRD_X+BIRD_SIZE+TUBE_WIDTH.
REQ-014 SHALL treat tube i as vertically safe when gap_y[i] <= bird_y and bird_y+BIRD_SIZE <= gap_y[i]+GAP_HEIGHT.
REQ-015 SHALL declare a hit when any tube overlaps and is not safe, or when bird_y == 0, or when bird_y+BIRD_SIZE >= SCREEN_HEIGHT.
REQ-016 SHALL compute all comparisons at 12-bit width with no wrap.
REQ-017 SHALL evaluate hit every cycle in PLAY and enter DEAD on the next edge (1-cycle latency), with run=0 from that edge.
REQ-018 SHALL register the previous tube_x per tube every cycle.
REQ-019 SHALL count a pass for tube i when prev >= BIRD_X and current < BIRD_X.
REQ-020 SHALL NOT count a pass on wrap-around (small to large tube_x).
REQ-021 SHALL increment score by the number of passes in a cycle (0..3) while in PLAY, saturating at 999.
REQ-022 SHALL give priority to hit when hit and pass occur in the same cycle: no score increment that cycle.
REQ-023 SHALL, on entry to DEAD, load high_score<=score if score > high_score, and clear the frame counter.
REQ-024 SHALL, in DEAD, count frame_tick pulses, move to OVER when the count reaches DEATH_FRAMES, and ignore btn_flap.
REQ-025 SHALL define OVER transitions:
- btn_flap in OVER: pulse game_rst, score<=0, next state PLAY.
- score and high_score hold while in OVER.
REQ-026 SHALL NOT let game_rst clear high_score.

Reset
REQ-027 SHALL, on rst, set state=IDLE, run=0, flap=0, game_rst=0, score=0, high_score=0, frame counter=0 and the prev tube_x registers=0.
REQ-028 SHALL let rst override every input in the same cycle, including a mid-PLAY hit or btn_flap.

Structure
REQ-029 SHALL place the state enum and the shared screen/bird constants in package game_pkg.
REQ-030 SHALL place the per-tube overlap/safe/pass logic in sub-module tube_hit, instantiated three times.
REQ-031 SHALL keep game_ctrl at 120-400 lines, with registered outputs only.

Verification
REQ-032 SHALL cover start: in IDLE, pulse btn_flap -> game_rst high one cycle, state=PLAY, run=1, score=0.
REQ-033 SHALL cover hit detection with tube_x[0]=300 and gap_y[0]=100:
- bird_y=150 -> no hit, state stays PLAY.
- bird_y=311 -> state=DEAD next cycle, run=0.
REQ-034 SHALL cover scoring with tube_x[1] stepping 202->200->198:
- 202->200: score unchanged.
- 200->198: score +1.
- tube_x[1] 2->240 (wrap): no change.
REQ-035 SHALL cover the floor: bird_y=728 in PLAY -> DEAD; high_score=score if larger.
REQ-036 SHALL cover the death timer and restart:
- In DEAD, 59 frame_ticks -> still DEAD; the 60th -> OVER.
- btn_flap in OVER -> game_rst pulse, PLAY, score=0, high_score retained.
REQ-037 SHALL cover rst asserted mid-PLAY with score=5 -> state=IDLE, score=0, high_score=0, run=0 the next cycle.
